// File: rtl/bp_update_scheduler_pkg.sv
// Shared types for the branch-predictor update scheduler: the update record
// carried from the resolution requesters through the queue to the predictor.
package bp_pkg;

  localparam int BP_DEFAULT_DEPTH = 4;
  localparam int BP_NUM_REQ       = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        mispredict;
  } bp_update_t;

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Bundle between branch-resolution requesters, the update scheduler and the
// predictor update port. The slave modport is the scheduler's view.
interface bp_update_scheduler_if #(
  parameter int NUM_REQ = bp_pkg::BP_NUM_REQ,
  parameter int DEPTH   = bp_pkg::BP_DEFAULT_DEPTH
);
  // Handshake: requester i transfers when req_valid[i] & req_ready[i] at a rising
  // clk edge; req_ready does not depend on req_valid. update_valid has no ready,
  // the predictor consumes every cycle it is high.
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_pc;
  logic [NUM_REQ-1:0][31:0] req_target;
  logic [NUM_REQ-1:0]       req_taken;
  logic [NUM_REQ-1:0]       req_mispredict;
  logic                     flush;
  logic                     update_valid;
  logic [31:0]              update_pc;
  logic                     update_taken;
  logic [31:0]              update_target;
  logic                     update_mispredict;
  logic [$clog2(DEPTH):0]   occupancy;
  logic [15:0]              mispredict_cnt;

  modport master (
    output req_valid, req_pc, req_target, req_taken, req_mispredict, flush,
    input  req_ready, update_valid, update_pc, update_taken, update_target,
           update_mispredict, occupancy, mispredict_cnt
  );

  modport slave (
    input  req_valid, req_pc, req_target, req_taken, req_mispredict, flush,
    output req_ready, update_valid, update_pc, update_taken, update_target,
           update_mispredict, occupancy, mispredict_cnt
  );
endinterface

// File: rtl/bp_update_scheduler_fifo.sv
// Circular update queue: two ordered write ports (port 1 lands behind port 0),
// one read port showing the head entry, and an occupancy count.
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = BP_DEFAULT_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [1:0]           wr_en,
  input  bp_update_t [1:0]     wr_data,
  input  logic                 rd_en,
  output bp_update_t           rd_data,
  output logic [CW-1:0]        count
);

  bp_update_t    mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] tail_p1;

  assign tail_p1 = tail + PW'(1);
  assign rd_data = mem[head];

  // Callers only assert wr_en[1] together with wr_en[0].
  always_ff @(posedge clk) begin
    if (wr_en[0]) mem[tail]    <= wr_data[0];
    if (wr_en[1]) mem[tail_p1] <= wr_data[1];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PW'(wr_en[0]) + PW'(wr_en[1]);
      head  <= head + PW'(rd_en);
      count <= count + CW'(wr_en[0]) + CW'(wr_en[1]) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/bp_update_scheduler.sv
// Branch-predictor update scheduler: orders resolved branches into a queue and
// streams them to the predictor. Optional same-cycle bypass: BP_UPD_BYPASS_EN.
module bp_update_scheduler
  import bp_pkg::*;
#(
  parameter int NUM_REQ = BP_NUM_REQ,
  parameter int DEPTH   = BP_DEFAULT_DEPTH
) (
  input logic                  clk,
  input logic                  rst,
  bp_update_scheduler_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]      count;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] acc;
  bp_update_t [1:0]   ent;
  bp_update_t [1:0]   wr_data;
  logic [1:0]         wr_en;
  bp_update_t         first;
  bp_update_t         second;
  bp_update_t         head_data;
  bp_update_t         upd_data;
  logic               upd_valid;
  logic               head_valid;
  logic               pop;
  logic               swap;
  logic [15:0]        mp_cnt;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ent[i].pc         = bus.req_pc[i];
      ent[i].target     = bus.req_target[i];
      ent[i].taken      = bus.req_taken[i];
      ent[i].mispredict = bus.req_mispredict[i];
    end
  end

  // Readiness uses the pre-pop count so a full queue refuses even while draining.
  assign ready[0]   = !rst && !bus.flush && (count < CW'(DEPTH));
  assign ready[1]   = !rst && !bus.flush && (count < CW'(DEPTH - 1));
  assign acc        = bus.req_valid & ready;
  assign head_valid = (count != '0);
  assign pop        = head_valid && !bus.flush && !rst;

  // A lone mispredict from requester 1 jumps ahead of a correct-path requester 0.
  assign swap   = acc[0] && acc[1] && ent[1].mispredict && !ent[0].mispredict;
  assign first  = (swap || !acc[0]) ? ent[1] : ent[0];
  assign second = swap ? ent[0] : ent[1];

`ifdef BP_UPD_BYPASS_EN
  logic bypass;
  assign bypass     = !head_valid && (acc != '0);
  assign wr_en      = bypass ? {1'b0, &acc} : {&acc, |acc};
  assign wr_data[0] = bypass ? second : first;
  assign wr_data[1] = second;
  assign upd_valid  = bypass || pop;
  assign upd_data   = bypass ? first : head_data;
`else
  assign wr_en      = {&acc, |acc};
  assign wr_data[0] = first;
  assign wr_data[1] = second;
  assign upd_valid  = pop;
  assign upd_data   = head_data;
`endif

  bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (bus.flush),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head_data),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mp_cnt <= '0;
    end else if (upd_valid && upd_data.mispredict && (mp_cnt != 16'hFFFF)) begin
      mp_cnt <= mp_cnt + 16'd1;
    end
  end

  assign bus.req_ready         = ready;
  assign bus.update_valid      = upd_valid;
  assign bus.update_pc         = rst ? '0 : upd_data.pc;
  assign bus.update_target     = rst ? '0 : upd_data.target;
  assign bus.update_taken      = rst ? 1'b0 : upd_data.taken;
  assign bus.update_mispredict = rst ? 1'b0 : upd_data.mispredict;
  assign bus.occupancy         = count;
  assign bus.mispredict_cnt    = mp_cnt;

endmodule
